// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network readout: state encoding and a
// constant-evaluable clog2 used to size index and window counters.
package snn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/spike_count_classifier_sat_counter.sv
// Saturating up-counter for one output neuron; clr wins over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/spike_count_classifier.sv
// Counts spikes per output neuron over a fixed window, then scans the
// counters one per cycle to report the lowest-index class with the most spikes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last result
// ST_RUN  | sampling spike_in for WINDOW cycles
// ST_SCAN | comparing one class counter per cycle against the best so far
// ST_DONE | result registered, done high for this single cycle
module spike_count_classifier
   import snn_pkg::*;
#(
   parameter int  NUM_OUTPUTS = 1,
   parameter int  COUNT_WIDTH = 16,
   parameter int  WINDOW      = 100,
   localparam int CLASS_W     = (NUM_OUTPUTS > 1) ? clog2(NUM_OUTPUTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_OUTPUTS-1:0] spike_in,
   output logic                   busy,
   output logic                   done,
   output logic [CLASS_W-1:0]     class_out,
   output logic [COUNT_WIDTH-1:0] max_count
);

   localparam int WIN_W = (clog2(WINDOW + 1) > 0) ? clog2(WINDOW + 1) : 1;

   state_t                 state_q, state_d;
   logic [WIN_W-1:0]       win_cnt;
   logic [CLASS_W-1:0]     scan_idx;
   logic [CLASS_W-1:0]     best_idx;
   logic [COUNT_WIDTH-1:0] best_cnt;
   logic [COUNT_WIDTH-1:0] counts [NUM_OUTPUTS];
   logic [COUNT_WIDTH-1:0] cnt_sel;
   logic                   clr_counts;
   logic                   win_last;
   logic                   scan_last;
   logic                   take;

   assign clr_counts = (state_q == ST_IDLE) && start;
   assign win_last   = (win_cnt == WIN_W'(WINDOW - 1));
   assign scan_last  = (scan_idx == CLASS_W'(NUM_OUTPUTS - 1));
   // Strictly-greater replacement keeps ties on the lowest index.
   assign take       = (scan_idx == '0) || (cnt_sel > best_cnt);

   for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
      sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr_counts),
         .inc   ((state_q == ST_RUN) && spike_in[g]),
         .count (counts[g])
      );
   end

   always_comb begin
      cnt_sel = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (scan_idx == CLASS_W'(i)) cnt_sel = counts[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)     state_d = ST_RUN;
         ST_RUN:  if (win_last)  state_d = ST_SCAN;
         ST_SCAN: if (scan_last) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt   <= '0;
         scan_idx  <= '0;
         best_idx  <= '0;
         best_cnt  <= '0;
         class_out <= '0;
         max_count <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  win_cnt  <= '0;
                  scan_idx <= '0;
               end
            end
            ST_RUN: win_cnt <= win_cnt + WIN_W'(1);
            ST_SCAN: begin
               if (!scan_last) scan_idx <= scan_idx + CLASS_W'(1);
               if (take) begin
                  best_idx <= scan_idx;
                  best_cnt <= cnt_sel;
               end
               // Fold the last comparison straight into the output registers.
               if (scan_last) begin
                  class_out <= take ? scan_idx : best_idx;
                  max_count <= take ? cnt_sel  : best_cnt;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier: a 4-bit and a 3-bit counter
// instance share stimulus; expected results are queued and checked on done.
module tb_spike_count_classifier;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] spike_in;

   logic       busy16, done16, busy8, done8;
   logic [1:0] class16, class8;
   logic [3:0] max16;
   logic [2:0] max8;

   int vectors     = 0;
   int miscompares = 0;

   logic [5:0] q16 [$];
   logic [5:0] q8  [$];
   logic [5:0] e16, e8;
   logic [3:0] pat [10];

   always #5 clk = ~clk;

   spike_count_classifier #(.NUM_OUTPUTS(4), .COUNT_WIDTH(4), .WINDOW(10)) dut (
      .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
      .busy(busy16), .done(done16), .class_out(class16), .max_count(max16)
   );

   spike_count_classifier #(.NUM_OUTPUTS(4), .COUNT_WIDTH(3), .WINDOW(10)) dut3 (
      .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
      .busy(busy8), .done(done8), .class_out(class8), .max_count(max8)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every done pops one queued expectation.
   always @(negedge clk) begin
      if (done16 === 1'b1) begin
         vectors++;
         assert (q16.size() != 0) else begin
            miscompares++;
            $error("FAIL done16_unexpected observed=%0h expected=none", {class16, max16});
         end
         if (q16.size() != 0) begin
            e16 = q16.pop_front();
            assert ({class16, max16} === e16) else begin
               miscompares++;
               $error("FAIL result16 observed=%0h expected=%0h", {class16, max16}, e16);
            end
         end
      end
      if (done8 === 1'b1) begin
         vectors++;
         assert (q8.size() != 0) else begin
            miscompares++;
            $error("FAIL done8_unexpected observed=%0h expected=none", {class8, max8});
         end
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            assert ({class8, 1'b0, max8} === e8) else begin
               miscompares++;
               $error("FAIL result8 observed=%0h expected=%0h", {class8, 1'b0, max8}, e8);
            end
         end
      end
   end

   task automatic push_expected();
      int c16 [4];
      int c8  [4];
      int b16, b8;
      for (int n = 0; n < 4; n++) begin
         c16[n] = 0;
         c8[n]  = 0;
      end
      for (int c = 0; c < 10; c++) begin
         for (int n = 0; n < 4; n++) begin
            if (pat[c][n]) begin
               if (c16[n] < 15) c16[n]++;
               if (c8[n]  < 7)  c8[n]++;
            end
         end
      end
      b16 = 0;
      b8  = 0;
      for (int n = 1; n < 4; n++) begin
         if (c16[n] > c16[b16]) b16 = n;
         if (c8[n]  > c8[b8])   b8  = n;
      end
      q16.push_back({2'(b16), 4'(c16[b16])});
      q8.push_back({2'(b8), 1'b0, 3'(c8[b8])});
   endtask

   // Drives one classification starting in the current (idle) cycle 0.
   task automatic run_class(input logic [3:0] fill, input bit restarts);
      push_expected();
      chk("idle_busy", {15'd0, busy16}, 16'd0);
      start    = 1'b1;
      spike_in = fill;
      step();
      for (int cyc = 1; cyc <= 15; cyc++) begin
         start    = restarts && (cyc == 3 || cyc == 15);
         spike_in = (cyc <= 10) ? pat[cyc-1] : fill;
         chk($sformatf("busy_c%0d", cyc), {15'd0, busy16}, 16'd1);
         chk($sformatf("done_c%0d", cyc), {15'd0, done16}, {15'd0, cyc == 15});
         if (cyc == 15) chk("done8_c15", {15'd0, done8}, 16'd1);
         step();
      end
      start    = 1'b0;
      spike_in = fill;
      chk("after_busy", {15'd0, busy16}, 16'd0);
      chk("after_done", {15'd0, done16}, 16'd0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      spike_in = 4'b0000;
      step();
      step();
      rst = 1'b0;
      chk("rst_busy",  {15'd0, busy16}, 16'd0);
      chk("rst_done",  {15'd0, done16}, 16'd0);
      chk("rst_class", {14'd0, class16}, 16'd0);
      chk("rst_max",   {12'd0, max16}, 16'd0);
      chk("rst_max8",  {13'd0, max8}, 16'd0);
      step();

      // 1: single neuron spiking every cycle
      for (int c = 0; c < 10; c++) pat[c] = 4'b0100;
      run_class(4'b0000, 1'b0);
      chk("s1_hold_class", {14'd0, class16}, 16'd2);
      chk("s1_hold_max",   {12'd0, max16}, 16'd10);
      step();

      // 2: tie between neurons 1 and 3 resolves to 1
      for (int c = 0; c < 10; c++) pat[c] = (c < 5) ? 4'b1010 : ((c < 9) ? 4'b0001 : 4'b0000);
      run_class(4'b0000, 1'b0);
      step();

      // 3: spikes only outside RUN are ignored
      for (int c = 0; c < 10; c++) pat[c] = 4'b0000;
      run_class(4'b1111, 1'b0);
      chk("s3_class", {14'd0, class16}, 16'd0);
      chk("s3_max",   {12'd0, max16}, 16'd0);
      spike_in = 4'b0000;
      step();

      // 4: saturation in the 3-bit instance
      for (int c = 0; c < 10; c++) pat[c] = (c < 6) ? 4'b0101 : 4'b0001;
      run_class(4'b0000, 1'b0);
      chk("s4_max8",   {13'd0, max8}, 16'd7);
      chk("s4_class8", {14'd0, class8}, 16'd0);
      step();

      // 5: start while busy ignored, back-to-back start right after DONE
      for (int c = 0; c < 10; c++) pat[c] = (c % 2 == 0) ? 4'b1000 : 4'b0010;
      run_class(4'b0000, 1'b1);
      for (int c = 0; c < 10; c++) pat[c] = 4'b0010;
      run_class(4'b0000, 1'b0);
      step();

      // 6: reset mid-RUN aborts with no done
      for (int c = 0; c < 10; c++) pat[c] = 4'b0100;
      start    = 1'b1;
      spike_in = 4'b0000;
      step();
      start = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         spike_in = 4'b0100;
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s6_busy",  {15'd0, busy16}, 16'd0);
      chk("s6_done",  {15'd0, done16}, 16'd0);
      chk("s6_class", {14'd0, class16}, 16'd0);
      chk("s6_max",   {12'd0, max16}, 16'd0);
      for (int cyc = 0; cyc < 20; cyc++) begin
         chk("s6_no_done", {15'd0, done16}, 16'd0);
         step();
      end
      spike_in = 4'b0000;
      for (int c = 0; c < 10; c++) pat[c] = 4'b0001;
      run_class(4'b0000, 1'b0);
      chk("s6_class_after", {14'd0, class16}, 16'd0);
      chk("s6_max_after",   {12'd0, max16}, 16'd10);
      step();

      chk("q16_drained", 16'(q16.size()), 16'd0);
      chk("q8_drained",  16'(q8.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spike_count_classifier.md
# spike_count_classifier

Readout stage placed directly downstream of `if_network`. It counts the spikes on each output neuron over a fixed window of clock cycles, then scans the counts sequentially to find the winner. It reports the winning class index and its count with a one-cycle `done` pulse. Sits between the network's `spike_out` bus and the host/control logic that issues one classification per input presentation.

## Interface
- `NUM_OUTPUTS`, 1: number of output neurons / classes; equals the network's `NUM_OUTPUTS`.
- `COUNT_WIDTH`, 16: width of each per-class spike counter.
- `WINDOW`, 100: number of cycles spikes are sampled per classification; legal range ≥1.
- `CLASS_W` (derived, not overridable): max(1, clog2(`NUM_OUTPUTS`)).

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous reset, active high.
- `start` input 1: request a classification; honoured only while `busy`=0.
- `spike_in` input `NUM_OUTPUTS`: spike bus from the network, one bit per neuron, sampled every RUN cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `class_out` / `max_count` are updated.
- `class_out` output `CLASS_W`: index of the winning neuron.
- `max_count` output `COUNT_WIDTH`: spike count of the winner.

## Operation
- States: IDLE, RUN, SCAN, DONE.
  - IDLE: `start`=1 → clear all counters and the window counter, go to RUN.
  - RUN: for each i with `spike_in[i]`=1, increment `count[i]`; window counter increments. After the `WINDOW`th RUN cycle, go to SCAN.
  - SCAN: one class per cycle, index 0 to `NUM_OUTPUTS`-1.
    - Index 0 loads best = (0, `count[0]`).
    - Index i>0 replaces best only if `count[i]` > best count (strictly greater), so ties resolve to the lowest index.
    - After the last index, go to DONE.
  - DONE: register best into `class_out` / `max_count`, assert `done`, return to IDLE.
- Counters saturate at 2^`COUNT_WIDTH`-1 and never wrap.
- Spikes arriving in IDLE, SCAN or DONE are ignored.
- `start` while `busy`=1 (including DONE) is ignored; nothing is queued.
- No spikes in the window → `class_out`=0, `max_count`=0, `done` still pulses.
- `class_out` / `max_count` hold their value until the next DONE.
- Reset (any state, including mid-RUN or mid-SCAN):
  - next cycle: state IDLE, `busy`=0, `done`=0, `class_out`=0, `max_count`=0;
  - all counters and the window counter are 0;
  - an aborted classification produces no `done`.

## Timing
- `start` accepted at cycle 0 (IDLE).
- RUN occupies cycles 1..`WINDOW`, and `spike_in` is sampled in each of those cycles.
- SCAN occupies cycles `WINDOW`+1 .. `WINDOW`+`NUM_OUTPUTS`.
- DONE is cycle `WINDOW`+`NUM_OUTPUTS`+1. `done`, `class_out` and `max_count` are registered and visible in that cycle.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- Earliest next accepted `start` is the cycle after DONE.
- Total latency from `start` to `done` = `WINDOW`+`NUM_OUTPUTS`+1 cycles.
- `spike_in` is used registered-internally only; there is no combinational path from any input to any output.

## Structure
- Shared package/header (`snn_pkg`):
  - state encoding constants;
  - clog2 helper used for `CLASS_W` and the window-counter width, which is clog2(`WINDOW`+1).
- One sub-module, `sat_counter`: parameter `WIDTH`; inputs `clk`, `rst`, `clr`, `inc`; output `count`. Saturating up-counter, `clr` has priority over `inc`. Instantiated `NUM_OUTPUTS` times in a generate loop.
- SCAN compares through a counter-indexed mux; there is no combinational argmax tree.

## Test plan
All scenarios use `NUM_OUTPUTS`=4, `WINDOW`=10, `COUNT_WIDTH`=4 unless stated.
1. `start` at cycle 0, `spike_in`=4'b0100 every cycle → `done` at cycle 15 only, `class_out`=2, `max_count`=10; `busy` high over cycles 1–15.
2. Within the window, neurons 1 and 3 each spike 5 times and neuron 0 spikes 4 times → `class_out`=1, `max_count`=5.
3. No spikes during the window, but `spike_in`=4'b1111 during IDLE and SCAN → `class_out`=0, `max_count`=0, `done` pulses.
4. `COUNT_WIDTH`=3, neuron 0 spikes every cycle and neuron 2 spikes 6 times → `max_count`=7, `class_out`=0 (saturation, no wrap).
5. `start` re-asserted at cycles 3 and 15 → single `done` at cycle 15; a new `start` at cycle 16 gives the next `done` at cycle 31.
6. `rst` asserted at cycle 5 mid-RUN → at cycle 6 `busy`=0 and all outputs are 0; no `done` follows. A fresh `start` with `spike_in`=4'b0001 gives `class_out`=0, `max_count`=10.
